// File: rtl/csr_pkg.sv
// CSR package: addresses, mstatus bit positions, decoder-facing types and the
// read-modify-write helper shared by the CSR file.
package csr_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // mstatus bit positions
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;

    // Writable bits of mie (MSIE, MTIE, MEIE)
    localparam logic [31:0] MIE_WMASK = 32'h0000_0888;

    // Trap vector / return address are word aligned
    localparam logic [31:0] ALIGN4_MASK = 32'hFFFF_FFFC;

    // Encodings follow funct3[1:0] of the Zicsr instructions
    typedef enum logic [1:0] {
        CSR_RW = 2'b01,
        CSR_RS = 2'b10,
        CSR_RC = 2'b11
    } csr_write_func_e;

    typedef enum logic {
        CSR_SRC_RS1  = 1'b0,
        CSR_SRC_UIMM = 1'b1
    } csr_input_sel_e;

    typedef struct packed {
        logic            read_enable;
        logic            write_enable;
        csr_write_func_e write_func;
        csr_input_sel_e  input_select;
    } csr_params_t;

    typedef logic [63:0] csr_counter64_t;

    // New CSR value for a read-modify-write; unknown encodings leave it unchanged
    function automatic logic [31:0] csr_apply(input csr_write_func_e func,
                                              input logic [31:0]     old_val,
                                              input logic [31:0]     src);
        case (func)
            CSR_RW:  return src;
            CSR_RS:  return old_val | src;
            CSR_RC:  return old_val & ~src;
            default: return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable halves.
module csr_counter64
    import csr_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_inc,
    input  logic           i_wr_lo,
    input  logic           i_wr_hi,
    input  logic [31:0]    i_wdata,
    output csr_counter64_t o_value
);

    csr_counter64_t r_value;

    // A write to either half takes precedence over the increment that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_wr_lo || i_wr_hi) begin
            if (i_wr_lo) r_value[31:0]  <= i_wdata;
            if (i_wr_hi) r_value[63:32] <= i_wdata;
        end else if (i_inc) begin
            r_value <= r_value + 64'd1;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: atomic read/modify/write, 64-bit counters and
// trap-entry / mret updates of the trap CSRs.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID    = 32'd0,
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_valid,
    input  csr_params_t csr_params,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_value,
    input  logic [4:0]  uimm,
    input  logic        instr_retire,
    input  logic        trap_enter,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_epc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    output logic        csr_rdata_valid,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        mstatus_mie
);

    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mie_en;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic        r_rdata_valid;
    logic [31:0] r_rdata;
    logic        r_illegal;

    logic [31:0]    w_src;
    logic [31:0]    w_old;
    logic [31:0]    w_new;
    logic           w_impl;
    logic           w_illegal;
    logic           w_wr_en;
    csr_counter64_t w_cycle;
    csr_counter64_t w_instret;

    assign w_src = (csr_params.input_select == CSR_SRC_UIMM) ? {27'd0, uimm} : rs1_value;

    // Read mux: current value of the addressed CSR and whether it exists
    always_comb begin
        w_impl = 1'b1;
        w_old  = '0;
        case (csr_addr)
            CSR_MSTATUS:                 w_old = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
            CSR_MISA:                    w_old = MISA_VALUE;
            CSR_MIE:                     w_old = r_mie_en;
            CSR_MTVEC:                   w_old = r_mtvec;
            CSR_MSCRATCH:                w_old = r_mscratch;
            CSR_MEPC:                    w_old = r_mepc;
            CSR_MCAUSE:                  w_old = r_mcause;
            CSR_MTVAL:                   w_old = r_mtval;
            CSR_MIP:                     w_old = '0;
            CSR_MCYCLE,    CSR_CYCLE:    w_old = w_cycle[31:0];
            CSR_MCYCLEH,   CSR_CYCLEH:   w_old = w_cycle[63:32];
            CSR_MINSTRET,  CSR_INSTRET:  w_old = w_instret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: w_old = w_instret[63:32];
            CSR_MHARTID:                 w_old = HART_ID;
            default:                     w_impl = 1'b0;
        endcase
    end

    assign w_illegal = !w_impl || (csr_params.write_enable && (csr_addr[11:10] == 2'b11));
    assign w_new     = csr_apply(csr_params.write_func, w_old, w_src);
    // Trap entry and mret both outrank a same-cycle CSR write
    assign w_wr_en   = csr_valid && csr_params.write_enable && !w_illegal && !trap_enter && !mret;

    csr_counter64 u_cycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (1'b1),
        .i_wr_lo (w_wr_en && (csr_addr == CSR_MCYCLE)),
        .i_wr_hi (w_wr_en && (csr_addr == CSR_MCYCLEH)),
        .i_wdata (w_new),
        .o_value (w_cycle)
    );

    csr_counter64 u_instret (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (instr_retire),
        .i_wr_lo (w_wr_en && (csr_addr == CSR_MINSTRET)),
        .i_wr_hi (w_wr_en && (csr_addr == CSR_MINSTRETH)),
        .i_wdata (w_new),
        .o_value (w_instret)
    );

    // CSR state: trap entry, then mret, then software writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mie_en   <= '0;
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else if (trap_enter) begin
            r_mepc   <= trap_epc & ALIGN4_MASK;
            r_mcause <= trap_cause;
            r_mtval  <= trap_tval;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    r_mie  <= w_new[MSTATUS_MIE_BIT];
                    r_mpie <= w_new[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      r_mie_en   <= w_new & MIE_WMASK;
                CSR_MTVEC:    r_mtvec    <= w_new & ALIGN4_MASK;
                CSR_MSCRATCH: r_mscratch <= w_new;
                CSR_MEPC:     r_mepc     <= w_new & ALIGN4_MASK;
                CSR_MCAUSE:   r_mcause   <= w_new;
                CSR_MTVAL:    r_mtval    <= w_new;
                default:      ;
            endcase
        end
    end

    // Registered response: pre-write value, zero on illegal or read_enable=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
            r_illegal     <= 1'b0;
        end else begin
            r_rdata_valid <= csr_valid;
            r_illegal     <= csr_valid && w_illegal;
            r_rdata       <= (csr_valid && csr_params.read_enable && !w_illegal) ? w_old : '0;
        end
    end

    assign csr_rdata_valid = r_rdata_valid;
    assign csr_rdata       = r_rdata;
    assign csr_illegal     = r_illegal;
    assign mtvec_out       = r_mtvec;
    assign mepc_out        = r_mepc;
    assign mstatus_mie     = r_mie;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: vector table plus hand-written counter,
// trap/mret and asynchronous-reset sequences.
module tb_csr_file;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        csr_valid;
    csr_params_t csr_params;
    logic [11:0] csr_addr;
    logic [31:0] rs1_value;
    logic [4:0]  uimm;
    logic        instr_retire;
    logic        trap_enter;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        mret;
    logic        csr_rdata_valid;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mstatus_mie;

    int n_checks = 0;
    int n_errors = 0;

    csr_file #(
        .HART_ID    (32'd0),
        .MISA_VALUE (32'h4000_0100)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .csr_valid       (csr_valid),
        .csr_params      (csr_params),
        .csr_addr        (csr_addr),
        .rs1_value       (rs1_value),
        .uimm            (uimm),
        .instr_retire    (instr_retire),
        .trap_enter      (trap_enter),
        .trap_cause      (trap_cause),
        .trap_epc        (trap_epc),
        .trap_tval       (trap_tval),
        .mret            (mret),
        .csr_rdata_valid (csr_rdata_valid),
        .csr_rdata       (csr_rdata),
        .csr_illegal     (csr_illegal),
        .mtvec_out       (mtvec_out),
        .mepc_out        (mepc_out),
        .mstatus_mie     (mstatus_mie)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [11:0]     addr;
        logic            we;
        logic            re;
        csr_write_func_e func;
        csr_input_sel_e  sel;
        logic [31:0]     rs1;
        logic [4:0]      uimm;
        logic [31:0]     exp_rdata;
        logic            exp_ill;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one CSR op for a single cycle; returns #1 after the committing edge
    task automatic do_op(input logic [11:0] a, input logic we, input logic re,
                         input csr_write_func_e f, input csr_input_sel_e s,
                         input logic [31:0] rs1, input logic [4:0] u);
        csr_valid               = 1'b1;
        csr_addr                = a;
        csr_params.read_enable  = re;
        csr_params.write_enable = we;
        csr_params.write_func   = f;
        csr_params.input_select = s;
        rs1_value               = rs1;
        uimm                    = u;
        @(posedge clk);
        #1;
        csr_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Plain read: RS with uimm=0 and no write
    task automatic rd(input logic [11:0] a);
        do_op(a, 1'b0, 1'b1, CSR_RS, CSR_SRC_UIMM, 32'd0, 5'd0);
    endtask

    task automatic check_resp(input string name, input logic [31:0] exp_data, input logic exp_ill);
        check({name, ".valid"}, {31'd0, csr_rdata_valid}, 32'd1);
        check({name, ".rdata"}, csr_rdata, exp_data);
        check({name, ".ill"},   {31'd0, csr_illegal}, {31'd0, exp_ill});
    endtask

    initial begin
        rst_n        = 1'b0;
        csr_valid    = 1'b0;
        csr_params   = '{read_enable: 1'b0, write_enable: 1'b0, write_func: CSR_RW, input_select: CSR_SRC_RS1};
        csr_addr     = '0;
        rs1_value    = '0;
        uimm         = '0;
        instr_retire = 1'b0;
        trap_enter   = 1'b0;
        trap_cause   = '0;
        trap_epc     = '0;
        trap_tval    = '0;
        mret         = 1'b0;

        vecs[0]  = '{"mhartid",      CSR_MHARTID,  1'b0, 1'b1, CSR_RS, CSR_SRC_UIMM, 32'h0,         5'd0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{"misa",         CSR_MISA,     1'b0, 1'b1, CSR_RS, CSR_SRC_UIMM, 32'h0,         5'd0, 32'h4000_0100, 1'b0};
        vecs[2]  = '{"mscr_rw",      CSR_MSCRATCH, 1'b1, 1'b1, CSR_RW, CSR_SRC_RS1,  32'hDEAD_BEEF, 5'd0, 32'h0000_0000, 1'b0};
        vecs[3]  = '{"mscr_rs",      CSR_MSCRATCH, 1'b1, 1'b1, CSR_RS, CSR_SRC_RS1,  32'h0000_0010, 5'd0, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{"mscr_rc",      CSR_MSCRATCH, 1'b1, 1'b1, CSR_RC, CSR_SRC_RS1,  32'hDEAD_0000, 5'd0, 32'hDEAD_BEFF, 1'b0};
        vecs[5]  = '{"mscr_rd",      CSR_MSCRATCH, 1'b0, 1'b1, CSR_RS, CSR_SRC_UIMM, 32'h0,         5'd0, 32'h0000_BEFF, 1'b0};
        vecs[6]  = '{"mtvec_wr",     CSR_MTVEC,    1'b1, 1'b1, CSR_RW, CSR_SRC_RS1,  32'h8000_0003, 5'd0, 32'h0000_0000, 1'b0};
        vecs[7]  = '{"mtvec_rd",     CSR_MTVEC,    1'b0, 1'b1, CSR_RS, CSR_SRC_UIMM, 32'h0,         5'd0, 32'h8000_0000, 1'b0};
        vecs[8]  = '{"cycle_wr",     CSR_CYCLE,    1'b1, 1'b1, CSR_RW, CSR_SRC_RS1,  32'h1234_5678, 5'd0, 32'h0000_0000, 1'b1};
        vecs[9]  = '{"unimpl_rd",    12'h7C0,      1'b0, 1'b1, CSR_RS, CSR_SRC_UIMM, 32'h0,         5'd0, 32'h0000_0000, 1'b1};
        vecs[10] = '{"mie_wr",       CSR_MIE,      1'b1, 1'b1, CSR_RW, CSR_SRC_RS1,  32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b0};
        vecs[11] = '{"mie_rd",       CSR_MIE,      1'b0, 1'b1, CSR_RS, CSR_SRC_UIMM, 32'h0,         5'd0, 32'h0000_0888, 1'b0};
        vecs[12] = '{"misa_wr",      CSR_MISA,     1'b1, 1'b1, CSR_RW, CSR_SRC_RS1,  32'h0,         5'd0, 32'h4000_0100, 1'b0};
        vecs[13] = '{"misa_rd2",     CSR_MISA,     1'b0, 1'b1, CSR_RS, CSR_SRC_UIMM, 32'h0,         5'd0, 32'h4000_0100, 1'b0};
        vecs[14] = '{"mepc_wr",      CSR_MEPC,     1'b1, 1'b1, CSR_RW, CSR_SRC_RS1,  32'h1234_5677, 5'd0, 32'h0000_0000, 1'b0};
        vecs[15] = '{"mepc_rd",      CSR_MEPC,     1'b0, 1'b1, CSR_RS, CSR_SRC_UIMM, 32'h0,         5'd0, 32'h1234_5674, 1'b0};
        vecs[16] = '{"noread",       CSR_MSCRATCH, 1'b0, 1'b0, CSR_RS, CSR_SRC_UIMM, 32'h0,         5'd0, 32'h0000_0000, 1'b0};
        vecs[17] = '{"mip_rd",       CSR_MIP,      1'b0, 1'b1, CSR_RS, CSR_SRC_UIMM, 32'h0,         5'd0, 32'h0000_0000, 1'b0};
        vecs[18] = '{"mstatus_wr",   CSR_MSTATUS,  1'b1, 1'b1, CSR_RW, CSR_SRC_RS1,  32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b0};
        vecs[19] = '{"mstatus_rd",   CSR_MSTATUS,  1'b0, 1'b1, CSR_RS, CSR_SRC_UIMM, 32'h0,         5'd0, 32'h0000_0088, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", {31'd0, csr_rdata_valid}, 32'd0);
        check("rst.rdata", csr_rdata, 32'd0);
        check("rst.mtvec", mtvec_out, 32'd0);
        check("rst.mepc",  mepc_out, 32'd0);
        check("rst.mie",   {31'd0, mstatus_mie}, 32'd0);
        rst_n = 1'b1;
        idle();

        // Vector table
        for (int i = 0; i < 20; i++) begin
            do_op(vecs[i].addr, vecs[i].we, vecs[i].re, vecs[i].func, vecs[i].sel, vecs[i].rs1, vecs[i].uimm);
            check_resp(vecs[i].name, vecs[i].exp_rdata, vecs[i].exp_ill);
        end
        check("mtvec_out", mtvec_out, 32'h8000_0000);
        check("mepc_out",  mepc_out,  32'h1234_5674);
        check("mie_out",   {31'd0, mstatus_mie}, 32'd1);
        idle();
        check("idle.valid", {31'd0, csr_rdata_valid}, 32'd0);

        // uimm operand path: RS mscratch with uimm 0x1F, then read back
        do_op(CSR_MSCRATCH, 1'b1, 1'b1, CSR_RS, CSR_SRC_UIMM, 32'hFFFF_FFFF, 5'h1F);
        check_resp("uimm_rs", 32'h0000_BEFF, 1'b0);
        do_op(CSR_MSCRATCH, 1'b1, 1'b1, CSR_RC, CSR_SRC_UIMM, 32'hFFFF_FFFF, 5'h10);
        check_resp("uimm_rc", 32'h0000_BEFF, 1'b0);
        rd(CSR_MSCRATCH);
        check_resp("uimm_rd", 32'h0000_BEEF, 1'b0);
        do_op(CSR_MSCRATCH, 1'b1, 1'b1, CSR_RW, CSR_SRC_RS1, 32'h0000_BEFF, 5'd0);

        // mcycle carry into mcycleh
        do_op(CSR_MCYCLEH, 1'b1, 1'b1, CSR_RW, CSR_SRC_RS1, 32'h0, 5'd0);
        do_op(CSR_MCYCLE,  1'b1, 1'b1, CSR_RW, CSR_SRC_RS1, 32'hFFFF_FFFE, 5'd0);
        rd(CSR_MCYCLE);
        check_resp("mcyc_lo", 32'hFFFF_FFFE, 1'b0);
        idle();
        rd(CSR_MCYCLEH);
        check_resp("mcyc_hi", 32'h0000_0001, 1'b0);

        // Illegal write to the cycle alias leaves the counter running
        do_op(CSR_MCYCLE, 1'b1, 1'b1, CSR_RW, CSR_SRC_RS1, 32'h0000_0100, 5'd0);
        rd(CSR_CYCLE);
        check_resp("cyc_a", 32'h0000_0100, 1'b0);
        do_op(CSR_CYCLE, 1'b1, 1'b1, CSR_RW, CSR_SRC_RS1, 32'h0, 5'd0);
        check_resp("cyc_ill", 32'h0, 1'b1);
        rd(CSR_CYCLE);
        check_resp("cyc_b", 32'h0000_0102, 1'b0);

        // minstret: write wins over a same-cycle retire, then counts retires
        instr_retire = 1'b1;
        do_op(CSR_MINSTRET, 1'b1, 1'b1, CSR_RW, CSR_SRC_RS1, 32'h0, 5'd0);
        repeat (3) idle();
        instr_retire = 1'b0;
        rd(CSR_MINSTRET);
        check_resp("instret", 32'h0000_0003, 1'b0);
        rd(CSR_INSTRETH);
        check_resp("instreth", 32'h0, 1'b0);

        // MIE=1, MPIE=0, then trap together with an mepc write
        do_op(CSR_MSTATUS, 1'b1, 1'b1, CSR_RW, CSR_SRC_RS1, 32'h0000_0008, 5'd0);
        check_resp("mst_set", 32'h0000_0088, 1'b0);
        trap_enter = 1'b1;
        trap_cause = 32'h0000_000B;
        trap_epc   = 32'h0000_0103;
        trap_tval  = 32'h0000_0055;
        do_op(CSR_MEPC, 1'b1, 1'b1, CSR_RW, CSR_SRC_RS1, 32'hAAAA_AAAC, 5'd0);
        trap_enter = 1'b0;
        check_resp("trap_op", 32'h1234_5674, 1'b0);
        check("trap.mepc_out", mepc_out, 32'h0000_0100);
        check("trap.mie_out",  {31'd0, mstatus_mie}, 32'd0);
        rd(CSR_MSTATUS);
        check_resp("trap.mstatus", 32'h0000_0080, 1'b0);
        rd(CSR_MCAUSE);
        check_resp("trap.mcause", 32'h0000_000B, 1'b0);
        rd(CSR_MTVAL);
        check_resp("trap.mtval", 32'h0000_0055, 1'b0);

        // mret with a concurrent mscratch write that must be dropped
        mret = 1'b1;
        do_op(CSR_MSCRATCH, 1'b1, 1'b1, CSR_RW, CSR_SRC_RS1, 32'h0000_0001, 5'd0);
        mret = 1'b0;
        check_resp("mret_op", 32'h0000_BEFF, 1'b0);
        check("mret.mie_out", {31'd0, mstatus_mie}, 32'd1);
        rd(CSR_MSTATUS);
        check_resp("mret.mstatus", 32'h0000_0088, 1'b0);
        rd(CSR_MSCRATCH);
        check_resp("mret.mscratch", 32'h0000_BEFF, 1'b0);

        // Asynchronous reset in the middle of an op
        csr_valid               = 1'b1;
        csr_addr                = CSR_MSCRATCH;
        csr_params.read_enable  = 1'b1;
        csr_params.write_enable = 1'b1;
        csr_params.write_func   = CSR_RW;
        csr_params.input_select = CSR_SRC_RS1;
        rs1_value               = 32'h1111_1111;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", {31'd0, csr_rdata_valid}, 32'd0);
        check("arst.rdata", csr_rdata, 32'd0);
        check("arst.mtvec", mtvec_out, 32'd0);
        check("arst.mepc",  mepc_out, 32'd0);
        check("arst.mie",   {31'd0, mstatus_mie}, 32'd0);
        csr_valid = 1'b0;
        idle();
        rst_n = 1'b1;
        idle();
        rd(CSR_MSCRATCH);
        check_resp("post_rst.mscratch", 32'h0, 1'b0);
        rd(CSR_MISA);
        check_resp("post_rst.misa", 32'h4000_0100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
